// File: rtl/sm_mult_arbiter.sv
// Two-requester round-robin arbiter in front of a sequential 4-bit shift-add
// sign-magnitude multiplier (5-bit operands, 9-bit result).
module sm_mult_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic [4:0] a0_i,
  input  logic [4:0] b0_i,
  input  logic [4:0] a1_i,
  input  logic [4:0] b1_i,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic [1:0] done_o,
  output logic [8:0] mult_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic       a_s;
    logic [3:0] a_m;
    logic       b_s;
    logic [3:0] b_m;
  } opnd_t;

  state_t     state;
  opnd_t      op;
  logic       owner;
  logic       rr_ptr;
  logic [7:0] acc;
  logic [1:0] cnt;
  logic [7:0] addend;
  logic [7:0] acc_nxt;

  // Gated by reset so no grant is visible while the block is held in reset.
  always_comb begin
    grant_o = 2'b00;
    if (rst_ni && state == IDLE) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = rr_ptr ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    addend  = op.a_m[cnt] ? ({4'b0000, op.b_m} << cnt) : 8'd0;
    acc_nxt = acc + addend;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      op     <= '0;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      acc    <= 8'd0;
      cnt    <= 2'd0;
      mult_o <= 9'd0;
      done_o <= 2'b00;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant_o) begin
            op     <= grant_o[1] ? opnd_t'({a1_i, b1_i}) : opnd_t'({a0_i, b0_i});
            owner  <= grant_o[1];
            rr_ptr <= grant_o[0];  // next tie goes to the other requester
            acc    <= 8'd0;
            cnt    <= 2'd0;
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Last partial product is folded in directly on the way out.
            mult_o <= {(op.a_s ^ op.b_s) & (|acc_nxt), acc_nxt};
            done_o <= owner ? 2'b10 : 2'b01;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 2'b00;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
